// File: rtl/mult_pipe_ctrl.sv
// Issue/hazard controller for the integer multiplier pipeline: tracks every multiply
// in flight, stalls decode on RAW/WAW/writeback-port hazards and flags forwarding.
module mult_pipe_ctrl #(
  parameter int STAGES  = 5,
  parameter int ALU_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              dec_valid_i,
  input  logic              dec_is_mult_i,
  input  logic [4:0]        dec_rd_i,
  input  logic              dec_rd_we_i,
  input  logic [4:0]        dec_rs1_i,
  input  logic [4:0]        dec_rs2_i,
  input  logic              dec_rs1_used_i,
  input  logic              dec_rs2_used_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              fwd_rs1_o,
  output logic              fwd_rs2_o,
  output logic [STAGES-1:0] mult_stage_valid_o,
  output logic              mult_wb_valid_o,
  output logic [4:0]        mult_wb_addr_o,
  output logic              busy_o,
  output logic [15:0]       stall_cnt_o
);
  localparam int LAST_IDX   = STAGES - 1;
  localparam int STRUCT_IDX = STAGES - ALU_LAT - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] we_q;
  logic [4:0]        rd_q [STAGES];
  logic [15:0]       stall_cnt_q;
  logic [15:0]       stall_cnt_d;

  logic rs1_chk_s, rs2_chk_s, alu_wr_s;
  logic rs1_young_s, rs1_old_s, rs2_young_s, rs2_old_s;
  logic struct_s, waw_s, stall_s, issue_s, entry_we_s;

  // Hazard detection of the decode instruction against every tracked multiply
  always_comb begin
    rs1_chk_s   = dec_rs1_used_i & (dec_rs1_i != 5'd0);
    rs2_chk_s   = dec_rs2_used_i & (dec_rs2_i != 5'd0);
    alu_wr_s    = ~dec_is_mult_i & dec_rd_we_i;
    rs1_young_s = 1'b0;
    rs1_old_s   = 1'b0;
    rs2_young_s = 1'b0;
    rs2_old_s   = 1'b0;
    struct_s    = 1'b0;
    waw_s       = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      rs1_young_s = rs1_young_s | ((k < LAST_IDX) & vld_q[k] & we_q[k] & rs1_chk_s
                                   & (rd_q[k] == dec_rs1_i));
      rs1_old_s   = rs1_old_s   | ((k == LAST_IDX) & vld_q[k] & we_q[k] & rs1_chk_s
                                   & (rd_q[k] == dec_rs1_i));
      rs2_young_s = rs2_young_s | ((k < LAST_IDX) & vld_q[k] & we_q[k] & rs2_chk_s
                                   & (rd_q[k] == dec_rs2_i));
      rs2_old_s   = rs2_old_s   | ((k == LAST_IDX) & vld_q[k] & we_q[k] & rs2_chk_s
                                   & (rd_q[k] == dec_rs2_i));
      // A non-mult write landing in the same cycle as a multiply fights for the port
      struct_s    = struct_s | ((k == STRUCT_IDX) & vld_q[k] & we_q[k] & alu_wr_s);
      waw_s       = waw_s | ((k <= STRUCT_IDX) & vld_q[k] & we_q[k] & alu_wr_s
                             & (dec_rd_i != 5'd0) & (rd_q[k] == dec_rd_i));
    end
    stall_s    = dec_valid_i & (rs1_young_s | rs2_young_s | struct_s | waw_s);
    issue_s    = dec_valid_i & dec_is_mult_i & ~stall_s & ~flush_i;
    entry_we_s = dec_rd_we_i & (dec_rd_i != 5'd0);
  end

  // Saturating stall counter next state
  always_comb begin
    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // In-flight multiply tracking shift register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      vld_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= 5'd0;
      end
    end else if (flush_i) begin
      vld_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q <= {vld_q[STAGES-2:0], issue_s};
      we_q  <= {we_q[STAGES-2:0], issue_s & entry_we_s};
      for (int k = STAGES - 1; k > 0; k--) begin
        rd_q[k] <= rd_q[k-1];
      end
      rd_q[0] <= dec_rd_i;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o            = stall_s;
  assign fwd_rs1_o          = dec_valid_i & rs1_old_s & ~rs1_young_s;
  assign fwd_rs2_o          = dec_valid_i & rs2_old_s & ~rs2_young_s;
  assign mult_stage_valid_o = vld_q;
  assign mult_wb_valid_o    = vld_q[LAST_IDX] & we_q[LAST_IDX];
  assign mult_wb_addr_o     = mult_wb_valid_o ? rd_q[LAST_IDX] : 5'd0;
  assign busy_o             = |vld_q;
  assign stall_cnt_o        = stall_cnt_q;
endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// Bench for mult_pipe_ctrl: directed scenarios with literal expectations plus a
// timestamp-based model of in-flight multiplies compared on every cycle.
module tb_mult_pipe_ctrl;
  localparam int S   = 5;
  localparam int ALU = 2;

  logic        clk = 1'b0;
  logic        rsn = 1'b0;
  logic        dec_valid = 1'b0, dec_is_mult = 1'b0, dec_rd_we = 1'b0;
  logic [4:0]  dec_rd = 5'd0, dec_rs1 = 5'd0, dec_rs2 = 5'd0;
  logic        dec_rs1_used = 1'b0, dec_rs2_used = 1'b0, flush = 1'b0;
  logic        stall, fwd1, fwd2, wbv, busy;
  logic [S-1:0] stage_vld;
  logic [4:0]  wba;
  logic [15:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mult_pipe_ctrl #(.STAGES(S), .ALU_LAT(ALU)) u_dut (
    .clk_i(clk), .rsn_i(rsn),
    .dec_valid_i(dec_valid), .dec_is_mult_i(dec_is_mult),
    .dec_rd_i(dec_rd), .dec_rd_we_i(dec_rd_we),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
    .flush_i(flush), .stall_o(stall), .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2),
    .mult_stage_valid_o(stage_vld), .mult_wb_valid_o(wbv), .mult_wb_addr_o(wba),
    .busy_o(busy), .stall_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted multiply is remembered by its issue cycle t; it writes back at t+S
  typedef struct {
    int         t;
    logic [4:0] rd;
    logic       we;
  } rec_t;
  rec_t         recs[$];
  rec_t         nr;
  int           cyc = 0;
  int           wb;
  logic [15:0]  m_cnt = 16'd0;
  logic [S-1:0] e_vld;
  logic         pend1, now1, pend2, now2, st, waw, alu_wr, e_stall, e_wbv;
  logic [4:0]   e_wba;

  always @(negedge clk) begin
    if (!rsn) begin
      recs.delete();
      m_cnt = 16'd0;
    end
    while (recs.size() != 0 && recs[0].t + S < cyc) void'(recs.pop_front());
    e_vld = '0; pend1 = 1'b0; now1 = 1'b0; pend2 = 1'b0; now2 = 1'b0;
    st = 1'b0; waw = 1'b0; e_wbv = 1'b0; e_wba = 5'd0;
    alu_wr = !dec_is_mult && dec_rd_we;
    foreach (recs[i]) begin
      wb = recs[i].t + S;
      e_vld[cyc - recs[i].t - 1] = 1'b1;
      if (recs[i].we) begin
        if (dec_rs1_used && dec_rs1 != 5'd0 && recs[i].rd == dec_rs1) begin
          if (wb > cyc) pend1 = 1'b1; else now1 = 1'b1;
        end
        if (dec_rs2_used && dec_rs2 != 5'd0 && recs[i].rd == dec_rs2) begin
          if (wb > cyc) pend2 = 1'b1; else now2 = 1'b1;
        end
        if (alu_wr && cyc + ALU == wb) st = 1'b1;
        if (alu_wr && dec_rd != 5'd0 && dec_rd == recs[i].rd && cyc + ALU <= wb) waw = 1'b1;
        if (wb == cyc) begin
          e_wbv = 1'b1;
          e_wba = recs[i].rd;
        end
      end
    end
    e_stall = dec_valid && (pend1 || pend2 || st || waw);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("fwd_rs1", 32'(fwd1), 32'(dec_valid && now1 && !pend1));
    chk("fwd_rs2", 32'(fwd2), 32'(dec_valid && now2 && !pend2));
    chk("stage_valid", 32'(stage_vld), 32'(e_vld));
    chk("wb_valid", 32'(wbv), 32'(e_wbv));
    chk("wb_addr", 32'(wba), 32'(e_wba));
    chk("busy", 32'(busy), 32'(e_vld != '0));
    chk("stall_cnt", 32'(cnt), 32'(m_cnt));
    if (rsn) begin
      if (flush) begin
        recs.delete();
      end else if (dec_valid && dec_is_mult && !e_stall) begin
        nr.t = cyc; nr.rd = dec_rd; nr.we = dec_rd_we && (dec_rd != 5'd0);
        recs.push_back(nr);
      end
      if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    cyc++;
  end

  task automatic drv(input logic v, input logic m, input logic [4:0] rd, input logic we,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic fl);
    dec_valid = v; dec_is_mult = m; dec_rd = rd; dec_rd_we = we;
    dec_rs1 = r1; dec_rs1_used = u1; dec_rs2 = r2; dec_rs2_used = u2; flush = fl;
  endtask
  task automatic idle(); drv(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); endtask
  task automatic smp(); @(negedge clk); endtask
  task automatic go(); @(posedge clk); #1; endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rsn = 1'b1;
    smp();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    go();

    // RAW: mult x5, dependent add held until forwarding cycle
    drv(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); smp();
    chk("s1_t0_stall", 32'(stall), 32'd0); go();
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); smp();
      chk("s1_raw_stall", 32'(stall), 32'd1); go();
    end
    smp();
    chk("s1_t5_stall", 32'(stall), 32'd0);
    chk("s1_t5_fwd", 32'(fwd1), 32'd1);
    chk("s1_t5_wbv", 32'(wbv), 32'd1);
    chk("s1_t5_wba", 32'(wba), 32'd5);
    chk("s1_t5_cnt", 32'(cnt), 32'd4);
    go(); idle(); repeat (6) go();

    // Writeback-port conflict
    drv(1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    idle(); go(); go();
    drv(1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); smp();
    chk("s2_t3_stall", 32'(stall), 32'd1);
    chk("s2_t3_stage", 32'(stage_vld), 32'h04); go();
    smp(); chk("s2_t4_stall", 32'(stall), 32'd0); go();
    idle(); smp();
    chk("s2_t5_wbv", 32'(wbv), 32'd1);
    chk("s2_t5_wba", 32'(wba), 32'd6);
    go(); repeat (5) go();

    // WAW
    drv(1'b1, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); smp();
      chk("s3_waw_stall", 32'(stall), 32'd1); go();
    end
    smp(); chk("s3_t4_stall", 32'(stall), 32'd0); go();
    idle(); repeat (6) go();

    // Multiply to x0 tracked but never written back
    drv(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    drv(1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); smp();
    chk("s4_x0_stall", 32'(stall), 32'd0);
    chk("s4_x0_fwd", 32'(fwd1), 32'd0); go();
    idle(); repeat (3) go();
    smp();
    chk("s4_t5_stage", 32'(stage_vld), 32'h10);
    chk("s4_t5_wbv", 32'(wbv), 32'd0);
    chk("s4_t5_wba", 32'(wba), 32'd0);
    go(); repeat (2) go();

    // Youngest match wins over the completing one
    drv(1'b1, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go(); go();
    idle(); repeat (3) go();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0); smp();
    chk("s5_young_stall", 32'(stall), 32'd1);
    chk("s5_young_fwd", 32'(fwd2), 32'd0); go();
    smp();
    chk("s5_old_stall", 32'(stall), 32'd0);
    chk("s5_old_fwd", 32'(fwd2), 32'd1); go();
    idle(); repeat (6) go();

    // Flush kills in-flight work and ignores the issue in the flush cycle
    drv(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    idle(); go();
    drv(1'b1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); smp();
    chk("s6_flush_stall", 32'(stall), 32'd0); go();
    idle(); smp();
    chk("s6_t3_stage", 32'(stage_vld), 32'h00);
    chk("s6_t3_busy", 32'(busy), 32'd0); go(); go();
    smp(); chk("s6_t5_wbv", 32'(wbv), 32'd0); go();

    // Flush together with a hazard still stalls
    drv(1'b1, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    drv(1'b1, 1'b0, 5'd2, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1); smp();
    chk("s7_flush_hazard_stall", 32'(stall), 32'd1); go();
    idle(); smp(); chk("s7_busy", 32'(busy), 32'd0); go();

    // Asynchronous reset with three multiplies in flight
    drv(1'b1, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    drv(1'b1, 1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    drv(1'b1, 1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); go();
    idle();
    smp(); chk("s8_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #3;
    rsn = 1'b0;
    #1;
    chk("s8_rst_stage", 32'(stage_vld), 32'h00);
    chk("s8_rst_busy", 32'(busy), 32'd0);
    chk("s8_rst_cnt", 32'(cnt), 32'd0);
    chk("s8_rst_wbv", 32'(wbv), 32'd0);
    go(); rsn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      smp(); chk("s8_no_wb", 32'(wbv), 32'd0); go();
    end

    // Saturation: a self-dependent multiply stream stalls 4 of every 5 cycles
    drv(1'b1, 1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
    repeat (82000) go();
    idle(); smp();
    chk("s9_cnt_sat", 32'(cnt), 32'h0000FFFF);
    go();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
